// File: rtl/attention_score_scheduler_if.sv
// rtl/attention_score_scheduler_if.sv - bus between the scheduler and the shared coincidence detector
// The scheduler is the master: it drives phases, fired flags and the latch strobe.
interface attention_score_scheduler_if;
  logic [7:0] cd_phase_a;
  logic [7:0] cd_phase_b;
  logic       cd_fired_a;
  logic       cd_fired_b;
  logic       cd_cycle_start;
  logic [7:0] cd_relevance;
  logic       cd_coincident;

  modport master (
    output cd_phase_a, cd_phase_b, cd_fired_a, cd_fired_b, cd_cycle_start,
    input  cd_relevance, cd_coincident
  );

  modport slave (
    input  cd_phase_a, cd_phase_b, cd_fired_a, cd_fired_b, cd_cycle_start,
    output cd_relevance, cd_coincident
  );
endinterface

// File: rtl/attention_score_scheduler.sv
// rtl/attention_score_scheduler.sv - scores N_KEYS keys against one query on a shared detector
// Each key takes an ISSUE/CAPTURE pair; inputs are snapshotted at start so they may change freely.
module attention_score_scheduler #(
  parameter int N_KEYS = 8,
  parameter int IDX_W  = $clog2(N_KEYS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [7:0]               query_phase,
  input  logic                     query_fired,
  input  logic [8*N_KEYS-1:0]      key_phase_flat,
  input  logic [N_KEYS-1:0]        key_fired,
  attention_score_scheduler_if.master cd,
  output logic                     busy,
  output logic                     done,
  output logic [8*N_KEYS-1:0]      score_flat,
  output logic [N_KEYS-1:0]        coinc_mask,
  output logic [IDX_W-1:0]         best_idx,
  output logic [7:0]               best_score,
  output logic                     best_valid
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_KEYS - 1);

  logic [1:0]              state_q,  state_d;
  logic [IDX_W-1:0]        idx_q,    idx_d;
  logic [7:0]              qph_q,    qph_d;
  logic                    qf_q,     qf_d;
  logic [8*N_KEYS-1:0]     kph_q,    kph_d;
  logic [N_KEYS-1:0]       kf_q,     kf_d;
  logic [7:0]              pa_q,     pa_d;
  logic [7:0]              pb_q,     pb_d;
  logic                    fa_q,     fa_d;
  logic                    fb_q,     fb_d;
  logic [8*N_KEYS-1:0]     score_q,  score_d;
  logic [N_KEYS-1:0]       coinc_q,  coinc_d;
  logic [IDX_W-1:0]        bidx_q,   bidx_d;
  logic [7:0]              bscore_q, bscore_d;
  logic                    bvalid_q, bvalid_d;
  logic [IDX_W-1:0]        idx_nx;

  assign idx_nx = idx_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    qph_d    = qph_q;
    qf_d     = qf_q;
    kph_d    = kph_q;
    kf_d     = kf_q;
    pa_d     = pa_q;
    pb_d     = pb_q;
    fa_d     = fa_q;
    fb_d     = fb_q;
    score_d  = score_q;
    coinc_d  = coinc_q;
    bidx_d   = bidx_q;
    bscore_d = bscore_q;
    bvalid_d = bvalid_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          qph_d    = query_phase;
          qf_d     = query_fired;
          kph_d    = key_phase_flat;
          kf_d     = key_fired;
          pa_d     = query_phase;
          fa_d     = query_fired;
          pb_d     = key_phase_flat[7:0];
          fb_d     = key_fired[0];
          score_d  = '0;
          coinc_d  = '0;
          bidx_d   = '0;
          bscore_d = '0;
          bvalid_d = 1'b0;
          idx_d    = '0;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = abort ? S_IDLE : S_CAPTURE;
      end
      S_CAPTURE: begin
        // abort pre-empts both the capture and the move to DONE
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          score_d[{idx_q, 3'b000} +: 8] = cd.cd_relevance;
          coinc_d[idx_q]                = cd.cd_coincident;
          if (cd.cd_relevance > bscore_q) begin
            bscore_d = cd.cd_relevance;
            bidx_d   = idx_q;
          end
          if (idx_q == LAST_IDX) begin
            bvalid_d = (bscore_d != 8'd0);
            state_d  = S_DONE;
          end else begin
            idx_d   = idx_nx;
            pb_d    = kph_q[{idx_nx, 3'b000} +: 8];
            fb_d    = kf_q[idx_nx];
            state_d = S_ISSUE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      qph_q    <= '0;
      qf_q     <= 1'b0;
      kph_q    <= '0;
      kf_q     <= '0;
      pa_q     <= '0;
      pb_q     <= '0;
      fa_q     <= 1'b0;
      fb_q     <= 1'b0;
      score_q  <= '0;
      coinc_q  <= '0;
      bidx_q   <= '0;
      bscore_q <= '0;
      bvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      qph_q    <= qph_d;
      qf_q     <= qf_d;
      kph_q    <= kph_d;
      kf_q     <= kf_d;
      pa_q     <= pa_d;
      pb_q     <= pb_d;
      fa_q     <= fa_d;
      fb_q     <= fb_d;
      score_q  <= score_d;
      coinc_q  <= coinc_d;
      bidx_q   <= bidx_d;
      bscore_q <= bscore_d;
      bvalid_q <= bvalid_d;
    end
  end

  assign cd.cd_phase_a     = pa_q;
  assign cd.cd_phase_b     = pb_q;
  assign cd.cd_fired_a     = fa_q;
  assign cd.cd_fired_b     = fb_q;
  assign cd.cd_cycle_start = (state_q == S_ISSUE);

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign score_flat = score_q;
  assign coinc_mask = coinc_q;
  assign best_idx   = bidx_q;
  assign best_score = bscore_q;
  assign best_valid = bvalid_q;

endmodule

// File: tb/tb_attention_score_scheduler.sv
// tb/tb_attention_score_scheduler.sv - randomized and directed bench with a request-level model
// A detector stand-in (tolerance 20, one-cycle latency) sits on the interface.
module tb_attention_score_scheduler;
  localparam int N   = 4;
  localparam int TOL = 20;
  localparam int DC  = 2 * N + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start, abort;
  logic [7:0]       query_phase;
  logic             query_fired;
  logic [8*N-1:0]   key_phase_flat;
  logic [N-1:0]     key_fired;
  logic             busy, done, best_valid;
  logic [8*N-1:0]   score_flat;
  logic [N-1:0]     coinc_mask;
  logic [1:0]       best_idx;
  logic [7:0]       best_score;

  attention_score_scheduler_if cdif ();

  attention_score_scheduler #(.N_KEYS(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .query_phase(query_phase), .query_fired(query_fired),
    .key_phase_flat(key_phase_flat), .key_fired(key_fired),
    .cd(cdif), .busy(busy), .done(done), .score_flat(score_flat),
    .coinc_mask(coinc_mask), .best_idx(best_idx), .best_score(best_score),
    .best_valid(best_valid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  function automatic int cdist(logic [7:0] a, logic [7:0] b);
    int d;
    d = (a > b) ? int'(a) - int'(b) : int'(b) - int'(a);
    return (d > 128) ? 256 - d : d;
  endfunction

  function automatic logic [7:0] rel_f(logic [7:0] a, logic [7:0] b, logic fa, logic fb);
    return (fa && fb) ? 8'(255 - cdist(a, b)) : 8'd0;
  endfunction

  function automatic logic coinc_f(logic [7:0] a, logic [7:0] b, logic fa, logic fb);
    return fa && fb && (cdist(a, b) <= TOL);
  endfunction

  logic [7:0] det_rel;
  logic       det_co;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      det_rel <= 8'd0;
      det_co  <= 1'b0;
    end else if (cdif.cd_cycle_start) begin
      det_rel <= rel_f(cdif.cd_phase_a, cdif.cd_phase_b, cdif.cd_fired_a, cdif.cd_fired_b);
      det_co  <= coinc_f(cdif.cd_phase_a, cdif.cd_phase_b, cdif.cd_fired_a, cdif.cd_fired_b);
    end
  end
  assign cdif.cd_relevance  = det_rel;
  assign cdif.cd_coincident = det_co;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Request-level model: t is the cycle number inside a request (0 = idle).
  int         t = 0;
  int         cyc = 0;
  logic [7:0] s_q;
  logic       s_qf;
  logic [7:0] s_k [N];
  logic       s_kf [N];
  logic [7:0] exp_score [N];
  logic [N-1:0] exp_coinc;
  logic       exp_bvalid;
  int         accepts [$];

  function automatic logic [8*N-1:0] pack_scores();
    logic [8*N-1:0] r;
    for (int i = 0; i < N; i++) r[8*i +: 8] = exp_score[i];
    return r;
  endfunction

  function automatic int argmax_idx();
    int bi = 0;
    for (int i = 1; i < N; i++) if (exp_score[i] > exp_score[bi]) bi = i;
    return bi;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t = 0;
      for (int i = 0; i < N; i++) exp_score[i] = 8'd0;
      exp_coinc  = '0;
      exp_bvalid = 1'b0;
    end else begin
      cyc++;
      if (t == 0) begin
        if (start) begin
          s_q  = query_phase;
          s_qf = query_fired;
          for (int i = 0; i < N; i++) begin
            s_k[i]       = key_phase_flat[8*i +: 8];
            s_kf[i]      = key_fired[i];
            exp_score[i] = 8'd0;
          end
          exp_coinc  = '0;
          exp_bvalid = 1'b0;
          accepts.push_back(cyc);
          t = 1;
        end
      end else if (t == DC) begin
        t = 0;
      end else if (abort) begin
        t = 0;
      end else begin
        if (t % 2 == 0) begin
          exp_score[t/2-1] = rel_f(s_q, s_k[t/2-1], s_qf, s_kf[t/2-1]);
          exp_coinc[t/2-1] = coinc_f(s_q, s_k[t/2-1], s_qf, s_kf[t/2-1]);
        end
        if (t == 2 * N) exp_bvalid = (exp_score[argmax_idx()] != 8'd0);
        t++;
      end
    end
  end

  logic chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("busy", 64'(busy), 64'(t != 0));
      chk("done", 64'(done), 64'(t == DC));
      chk("cycle_start", 64'(cdif.cd_cycle_start), 64'((t % 2 == 1) && (t < DC)));
      if ((t % 2 == 1) && (t < DC)) begin
        chk("cd_phase_a", 64'(cdif.cd_phase_a), 64'(s_q));
        chk("cd_fired_a", 64'(cdif.cd_fired_a), 64'(s_qf));
        chk("cd_phase_b", 64'(cdif.cd_phase_b), 64'(s_k[(t-1)/2]));
        chk("cd_fired_b", 64'(cdif.cd_fired_b), 64'(s_kf[(t-1)/2]));
      end
      chk("score_flat", 64'(score_flat), 64'(pack_scores()));
      chk("coinc_mask", 64'(coinc_mask), 64'(exp_coinc));
      chk("best_valid", 64'(best_valid), 64'(exp_bvalid));
      if (t == 0 || t == DC) begin
        chk("best_idx", 64'(best_idx), 64'(argmax_idx()));
        chk("best_score", 64'(best_score), 64'(exp_score[argmax_idx()]));
      end
    end
  end

  task automatic start_req(logic [7:0] q, logic qf, logic [8*N-1:0] k, logic [N-1:0] kf);
    query_phase    = q;
    query_fired    = qf;
    key_phase_flat = k;
    key_fired      = kf;
    start          = 1'b1;
    @(negedge clk);
    start          = 1'b0;
  endtask

  task automatic wait_done(output int n, output logic [15:0] cs_mask);
    n = 1;
    cs_mask = '0;
    cs_mask[1] = cdif.cd_cycle_start;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      cs_mask[n[3:0]] = cdif.cd_cycle_start;
    end
    if (!done) chk("done_timeout", 64'(n), 64'(DC));
  endtask

  localparam logic [8*N-1:0] K_BASIC = {8'd40, 8'd138, 8'd250, 8'd10};
  localparam logic [8*N-1:0] K_TIES  = {8'd255, 8'd1, 8'd255, 8'd128};

  int          n;
  logic [15:0] cs;
  int          dones;

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    query_phase = '0; query_fired = 1'b0; key_phase_flat = '0; key_fired = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_score", 64'(score_flat), 64'd0);
    chk("rst_best", 64'({best_idx, best_score, best_valid}), 64'd0);
    chk("rst_cd", 64'({cdif.cd_phase_a, cdif.cd_phase_b, cdif.cd_fired_a,
                       cdif.cd_fired_b, cdif.cd_cycle_start}), 64'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    start_req(8'd10, 1'b1, K_BASIC, 4'hF);
    wait_done(n, cs);
    chk("basic_latency", 64'(n), 64'd9);
    chk("basic_cs_cycles", 64'(cs), 64'h00AA);
    chk("basic_scores", 64'(score_flat), 64'hE17FEFFF);
    chk("basic_coinc", 64'(coinc_mask), 64'b0011);
    chk("basic_best", 64'({best_idx, best_score, best_valid}), {53'd0, 2'd0, 8'd255, 1'b1});
    @(negedge clk);
    chk("basic_single_pulse", 64'(done), 64'd0);

    start_req(8'd0, 1'b1, K_TIES, 4'hF);
    wait_done(n, cs);
    chk("ties_scores", 64'(score_flat), 64'hFEFEFE7F);
    chk("ties_coinc", 64'(coinc_mask), 64'b1110);
    chk("ties_best", 64'({best_idx, best_score}), {54'd0, 2'd1, 8'd254});
    @(negedge clk);

    start_req(8'd10, 1'b1, K_BASIC, 4'h0);
    wait_done(n, cs);
    chk("unfired_k", 64'({score_flat, best_idx, best_valid}), 64'd0);
    @(negedge clk);
    start_req(8'd10, 1'b0, K_BASIC, 4'hF);
    wait_done(n, cs);
    chk("unfired_q", 64'({score_flat, best_idx, best_valid}), 64'd0);
    @(negedge clk);

    start_req(8'd10, 1'b1, K_BASIC, 4'hF);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_score0", 64'(score_flat[7:0]), 64'd255);
    chk("abort_bvalid", 64'(best_valid), 64'd0);
    @(negedge clk);
    start_req(8'd0, 1'b1, K_TIES, 4'hF);
    wait_done(n, cs);
    chk("after_abort_latency", 64'(n), 64'd9);
    @(negedge clk);

    start_req(8'd10, 1'b1, K_BASIC, 4'hF);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out", 64'({busy, done, best_valid, best_score, score_flat}), 64'd0);
    chk("midrst_cd", 64'({cdif.cd_phase_a, cdif.cd_phase_b, cdif.cd_cycle_start}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_req(8'd10, 1'b1, K_BASIC, 4'hF);
    wait_done(n, cs);
    chk("postrst_scores", 64'(score_flat), 64'hE17FEFFF);
    @(negedge clk);

    start_req(8'd10, 1'b1, K_BASIC, 4'hF);
    repeat (5) begin
      key_phase_flat = {$urandom, $urandom};
      query_phase    = 8'($urandom);
      @(negedge clk);
    end
    wait_done(n, cs);
    chk("snapshot_scores", 64'(score_flat), 64'hE17FEFFF);
    @(negedge clk);

    accepts.delete();
    dones = 0;
    query_phase = 8'd10; query_fired = 1'b1; key_phase_flat = K_BASIC; key_fired = 4'hF;
    start = 1'b1;
    repeat (31) begin
      @(negedge clk);
      if (done) dones++;
    end
    start = 1'b0;
    chk("b2b_dones", 64'(dones), 64'd3);
    chk("b2b_accepts", 64'(accepts.size()), 64'd4);
    if (accepts.size() >= 3) begin
      chk("b2b_gap1", 64'(accepts[1] - accepts[0]), 64'd10);
      chk("b2b_gap2", 64'(accepts[2] - accepts[1]), 64'd10);
    end
    wait_done(n, cs);
    @(negedge clk);

    repeat (900) begin
      start       = ($urandom_range(0, 3) == 0);
      abort       = ($urandom_range(0, 19) == 0);
      query_phase = 8'($urandom);
      query_fired = ($urandom_range(0, 7) != 0);
      for (int i = 0; i < N; i++)
        key_phase_flat[8*i +: 8] = ($urandom_range(0, 1) == 0) ?
            8'(query_phase + 8'($urandom_range(0, 50)) - 8'd25) : 8'($urandom);
      key_fired = 4'($urandom) | 4'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    abort = 1'b0;
    repeat (12) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
